// File: rtl/vfx_pkg.sv
// rtl/vfx_pkg.sv - shared pixel types, kernel selects and source FSM states
package vfx_pkg;

  localparam int PIXEL_W = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    KERNEL_1X1 = 3'b000,
    KERNEL_3X3 = 3'b001,
    KERNEL_5X5 = 3'b010
  } kernel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } src_state_e;

endpackage

// File: rtl/pixel_xy_counter.sv
// rtl/pixel_xy_counter.sv - raster x/y counters with enable and terminal-count flags
module pixel_xy_counter #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  parameter int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic first,
  output logic line_end,
  output logic frame_end
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign first     = (x == '0) && (y == '0);
  assign line_end  = (x == XW'(IMG_WIDTH - 1));
  assign frame_end = line_end && (y == YW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (line_end) begin
        x <= '0;
        y <= frame_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - raster frame-buffer reader feeding a filter stream
// Optional test-pattern source enabled by FRAME_SOURCE_TEST_PATTERN_EN.
module frame_stream_source
  import vfx_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        freq_flag_in,
  input  logic              hold,
`ifdef FRAME_SOURCE_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  pixel_t            rd_data,
  output logic              ready_out,
  output pixel_t            data_out,
  output logic [2:0]        freq_flag,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy
);

  // Assertion is immediate, release is re-timed to clk.
  logic [1:0] rst_pipe;
  logic       rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  src_state_e  state;
  logic        issue, first, line_end, frame_end, use_pattern;
  logic        p1_valid, p1_sof, p1_eol, p1_eof;
  pixel_t      p1_pat;

`ifdef FRAME_SOURCE_TEST_PATTERN_EN
  logic test_mode_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           test_mode_q <= 1'b0;
    else if (state == S_IDLE && start) test_mode_q <= test_mode;
  end
  assign use_pattern = test_mode_q;
`else
  assign use_pattern = 1'b0;
`endif

  // A read slot is consumed every non-held STREAM cycle, even in pattern mode.
  assign issue = (state == S_STREAM) && !hold;
  assign rd_en = issue && !use_pattern;
  assign busy  = (state != S_IDLE);

  pixel_xy_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_xy (
    .clk      (clk),
    .rst      (rst),
    .en       (issue),
    .first    (first),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      freq_flag <= 3'b000;
      p1_valid  <= 1'b0;
      p1_sof    <= 1'b0;
      p1_eol    <= 1'b0;
      p1_eof    <= 1'b0;
      p1_pat    <= '0;
      ready_out <= 1'b0;
      data_out  <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state     <= S_STREAM;
          freq_flag <= freq_flag_in;
        end
        S_STREAM: if (issue && frame_end) state <= S_DRAIN;
        S_DRAIN:  if (ready_out && eof)   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (issue) rd_addr <= frame_end ? '0 : rd_addr + 1'b1;

      // Stage 1 lines up with rd_data; stage 2 is the registered output.
      p1_valid <= issue;
      p1_sof   <= issue && first;
      p1_eol   <= issue && line_end;
      p1_eof   <= issue && frame_end;
      p1_pat   <= pixel_t'(rd_addr);

      ready_out <= p1_valid;
      sof       <= p1_sof;
      eol       <= p1_eol;
      eof       <= p1_eof;
      if (p1_valid) data_out <= use_pattern ? p1_pat : rd_data;
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// tb/tb_frame_stream_source.sv - scoreboard bench for frame_stream_source (15x15 frames)
module tb_frame_stream_source;

  localparam int W = 15;
  localparam int H = 15;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  freq_flag_in = 3'b000;
  logic [11:0] rd_data = 12'h000;
  logic        rd_en, ready_out, sof, eol, eof, busy;
  logic [16:0] rd_addr;
  logic [11:0] data_out;
  logic [2:0]  freq_flag;
`ifdef FRAME_SOURCE_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  frame_stream_source #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (17)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .freq_flag_in(freq_flag_in),
    .hold        (hold),
`ifdef FRAME_SOURCE_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .freq_flag   (freq_flag),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Frame buffer holding RAM[k] = k, one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= 12'(rd_addr);

  typedef struct packed {
    logic [11:0] d;
    logic        s;
    logic        l;
    logic        e;
    logic [2:0]  f;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;
  int   popped = 0;
  int   rd_en_seen = 0;
  int   gap_cycles = 0;
  bit   in_frame = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [2:0] f);
    for (int k = 0; k < NPIX; k++)
      q.push_back({12'(k), k == 0, (k % W) == W - 1, k == NPIX - 1, f});
  endtask

  task automatic pulse_start(input logic [2:0] f);
    @(negedge clk);
    freq_flag_in = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_eof();
    int n = 0;
    while (!(ready_out && eof) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("eof_timeout", 0, 1);
  endtask

  task automatic wait_popped(input int target);
    int n = 0;
    while (popped < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("popped_timeout", 0, 1);
  endtask

  // Monitor: pops one expectation per ready_out and tracks gaps inside a frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_en) rd_en_seen++;
      if (ready_out) begin
        if (q.size() == 0) begin
          check("unexpected_pixel", {data_out, sof, eol, eof}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pixel", {data_out, sof, eol, eof, freq_flag}, e);
        end
        popped++;
        if (sof) in_frame = 1'b1;
        if (eof) in_frame = 1'b0;
      end else begin
        if (in_frame) gap_cycles++;
        if (sof | eol | eof) check("flags_without_ready", {sof, eol, eof}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rd_en, rd_addr, ready_out, data_out, freq_flag, sof, eol, eof, busy}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Frame 1: plain stream, latency and qualifiers.
    popped = 0; gap_cycles = 0;
    push_frame(3'b001);
    check("busy_before_start", busy, 0);
    freq_flag_in = 3'b001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1);
    check("first_rd", {rd_en, rd_addr}, {1'b1, 17'd0});
    while (!ready_out && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    wait_eof();
    @(negedge clk);
    check("f1_count", popped, NPIX);
    check("f1_gaps", gap_cycles, 0);
    check("f1_busy_after_eof", busy, 0);
    check("f1_queue_empty", q.size(), 0);

    // Frame 2: hold for 4 cycles at pixel 20.
    popped = 0; gap_cycles = 0;
    push_frame(3'b010);
    pulse_start(3'b010);
    lat = 0;
    while (!(rd_en && rd_addr == 17'd20) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("reach_pixel20", lat < 100, 1);
    hold = 1'b1;
    @(negedge clk);
    check("hold_rd", {rd_en, rd_addr}, {1'b0, 17'd20});
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_eof();
    @(negedge clk);
    check("f2_count", popped, NPIX);
    check("f2_gaps", gap_cycles, 4);

    // Frame 3: second start mid-frame with another kernel is ignored.
    popped = 0; gap_cycles = 0;
    push_frame(3'b001);
    pulse_start(3'b001);
    wait_popped(50);
    pulse_start(3'b101);
    wait_eof();
    @(negedge clk);
    check("f3_count", popped, NPIX);
    check("f3_busy_after_eof", busy, 0);

    // Frame 4: start coinciding with eof is ignored.
    popped = 0;
    push_frame(3'b000);
    pulse_start(3'b000);
    wait_eof();
    freq_flag_in = 3'b110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_eof_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("start_at_eof_no_frame", {busy, rd_en, ready_out}, 0);
    check("f4_count", popped, NPIX);

    // Frame 5: reset after 100 pixels, then a clean frame from address 0.
    popped = 0;
    push_frame(3'b010);
    pulse_start(3'b010);
    wait_popped(100);
    reset = 1'b1;
    #1;
    check("reset_mid_outputs",
          {rd_en, rd_addr, ready_out, data_out, freq_flag, sof, eol, eof, busy}, 0);
    q.delete();
    in_frame = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    popped = 0; gap_cycles = 0;
    push_frame(3'b001);
    pulse_start(3'b001);
    wait_eof();
    @(negedge clk);
    check("f5_count", popped, NPIX);
    check("f5_gaps", gap_cycles, 0);

`ifdef FRAME_SOURCE_TEST_PATTERN_EN
    // Frame 6: internal gradient, frame buffer untouched.
    popped = 0; rd_en_seen = 0;
    test_mode = 1'b1;
    push_frame(3'b010);
    pulse_start(3'b010);
    test_mode = 1'b0;
    wait_eof();
    @(negedge clk);
    check("tp_count", popped, NPIX);
    check("tp_rd_en_never", rd_en_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/frame_stream_source.md
FRAME_STREAM_SOURCE -- requirements
Module: frame_stream_source

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter ADDR_W, default 17, frame-buffer address width; SHALL satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins one frame transfer.
REQ-007 freq_flag_in  input  3  kernel select; captured at an accepted start.
REQ-008 hold  input  1  pauses the stream while high.
REQ-009 rd_en  output  1  frame-buffer read strobe.
REQ-010 rd_addr  output  ADDR_W  frame-buffer read address, raster order.
REQ-011 rd_data  input  12  frame-buffer data, valid exactly one cycle after rd_en.
REQ-012 ready_out  output  1  data_out valid this cycle; drives the filter's ready_in.
REQ-013 data_out  output  12  RGB444 pixel; drives the filter's data_in.
REQ-014 freq_flag  output  3  captured kernel select, constant for the whole frame.
REQ-015 sof / eol / eof  output  1 each  qualifiers; high only with ready_out on the first pixel / last pixel of a line / last pixel of the frame.
REQ-016 busy  output  1  high from the cycle after an accepted start until the cycle after eof.

Function
REQ-017 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on start; STREAM->DRAIN after the final rd_en; DRAIN->IDLE after the final ready_out.
REQ-018 start SHALL be accepted only in IDLE; start while busy is ignored and does not affect the frame in progress.
REQ-019 In STREAM, on each cycle with hold=0, assert rd_en with rd_addr = y*IMG_WIDTH + x, then advance x (wrapping at IMG_WIDTH-1 to 0 and incrementing y).
REQ-020 With hold=1, rd_en is 0 and x, y and rd_addr are unchanged.
REQ-021 data_out SHALL register rd_data; ready_out SHALL be rd_en delayed by 2 cycles.
REQ-022 Latency: start sampled at cycle 0 gives the first rd_en at cycle 1 and the first ready_out at cycle 3.
REQ-023 Exactly IMG_WIDTH*IMG_HEIGHT ready_out pulses per frame; no pixel is dropped or duplicated under any hold pattern.
REQ-024 hold SHALL NOT cancel reads already issued; those pixels still emerge on ready_out.
REQ-025 If start coincides with the cycle of eof, start is ignored; a new start is accepted only once busy=0.
REQ-026 When ready_out=0, data_out holds its last value and sof/eol/eof are 0.

Reset
REQ-027 Asynchronous assert of reset SHALL force IDLE, x=y=0, and all outputs to 0 (rd_en, rd_addr, ready_out, data_out, freq_flag, sof, eol, eof, busy).
REQ-028 Reset mid-frame abandons the frame; pipelined pixels are discarded, and the next start restarts at address 0.
REQ-029 Reset deassertion SHALL be synchronous to clk.

Configuration
REQ-030 Macro FRAME_SOURCE_TEST_PATTERN_EN, when defined, adds input test_mode (1 bit, captured at start).
REQ-031 With the macro defined and test_mode=1, data_out = (y*IMG_WIDTH + x) & 12'hFFF, rd_en stays 0, and timing is identical to RAM mode.
REQ-032 Without the macro, test_mode is absent and pixels come only from rd_data.

Structure
REQ-033 Shared package vfx_pkg SHALL hold PIXEL_W=12, typedef pixel_t, and the kernel enum: KERNEL_1X1=3'b000, KERNEL_3X3=3'b001, KERNEL_5X5=3'b010.
REQ-034 Sub-module pixel_xy_counter SHALL implement the x/y raster counters with enable and line/frame terminal-count flags.

Verification (IMG_WIDTH=IMG_HEIGHT=15 in all cases)
REQ-035 RAM[k]=k, start, freq_flag_in=3'b001, hold=0 -> first ready_out 3 cycles after start, with data_out 0x000..0x0E0 on 225 consecutive cycles, sof at 0x000, eol at 0x00E, eof at 0x0E0, and freq_flag=3'b001 throughout.
REQ-036 hold high for 4 cycles at pixel 20 -> exactly 4 ready_out gaps, and the sequence stays 0..224 with no drop or duplicate.
REQ-037 A second start issued mid-frame -> ignored, and still exactly 225 pixels are output.
REQ-038 reset asserted after 100 pixels -> all outputs 0 immediately; a later start produces a full frame beginning at 0x000.
REQ-039 With FRAME_SOURCE_TEST_PATTERN_EN defined and test_mode=1 -> gradient 0x000..0x0E0 is output and rd_en never asserts.
